// File: rtl/memory_dump_unit.sv
// Post-halt data memory dump: reads every word from address 0 upward and offers it on a valid/ready port.
// Optional DUMP_SKIP_ZERO_EN suppresses zero words instead of offering them.
//
// state | meaning
// IDLE  | waiting for halt
// READ  | read strobe issued at counter
// WAIT  | memory data returning, captured into dump registers
// SEND  | word offered, waiting for dump_ready
// DONE  | dump finished, sticky until reset
module memory_dump_unit #(
   parameter int ADDRESS_WIDTH = 12
) (
   input  logic                     CLK,
   input  logic                     reset,
   input  logic                     halt,
   output logic                     mem_read_enable,
   output logic [ADDRESS_WIDTH-1:0] mem_address,
   input  logic [31:0]              mem_data,
   output logic                     dump_valid,
   input  logic                     dump_ready,
   output logic [ADDRESS_WIDTH-1:0] dump_address,
   output logic [31:0]              dump_data,
   output logic                     dump_done
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_WAIT,
      ST_SEND,
      ST_DONE
   } state_t;

   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = {{(ADDRESS_WIDTH-2){1'b1}}, 2'b00};
   localparam logic [ADDRESS_WIDTH-1:0] STRIDE    = ADDRESS_WIDTH'(4);

`ifdef DUMP_SKIP_ZERO_EN
   localparam bit SKIP_ZERO = 1'b1;
`else
   localparam bit SKIP_ZERO = 1'b0;
`endif

   state_t                     r_state;
   logic [ADDRESS_WIDTH-1:0]   r_counter;
   logic [ADDRESS_WIDTH-1:0]   r_dump_address;
   logic [31:0]                r_dump_data;

   state_t                     w_state_nxt;
   logic [ADDRESS_WIDTH-1:0]   w_counter_nxt;
   logic                       w_capture;
   logic                       w_last;

   assign w_last = (r_counter == LAST_ADDR);

   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         r_state        <= ST_IDLE;
         r_counter      <= '0;
         r_dump_address <= '0;
         r_dump_data    <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_counter <= w_counter_nxt;
         if (w_capture) begin
            r_dump_address <= r_counter;
            r_dump_data    <= mem_data;
         end
      end
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_counter_nxt = r_counter;
      w_capture     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (halt) begin
               w_state_nxt   = ST_READ;
               w_counter_nxt = '0;
            end
         end
         ST_READ: w_state_nxt = ST_WAIT;
         ST_WAIT: begin
            w_capture = 1'b1;
            // a suppressed zero word advances exactly like an accepted one
            if (SKIP_ZERO && (mem_data == 32'h0)) begin
               if (w_last) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt   = ST_READ;
                  w_counter_nxt = r_counter + STRIDE;
               end
            end else begin
               w_state_nxt = ST_SEND;
            end
         end
         ST_SEND: begin
            if (dump_ready) begin
               if (w_last) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt   = ST_READ;
                  w_counter_nxt = r_counter + STRIDE;
               end
            end
         end
         ST_DONE: w_state_nxt = ST_DONE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign mem_read_enable = (r_state == ST_READ);
   assign mem_address     = r_counter;
   assign dump_valid      = (r_state == ST_SEND);
   assign dump_done       = (r_state == ST_DONE);
   assign dump_address    = r_dump_address;
   assign dump_data       = r_dump_data;

endmodule

// File: tb/tb_memory_dump_unit.sv
// Directed bench for memory_dump_unit with a 4-word memory (ADDRESS_WIDTH=4).
// Expectations follow DUMP_SKIP_ZERO_EN when the bench is built with it.
module tb_memory_dump_unit;

   localparam int AW = 4;

   logic          CLK = 1'b0;
   logic          reset = 1'b1;
   logic          halt = 1'b0;
   logic          mem_read_enable;
   logic [AW-1:0] mem_address;
   logic [31:0]   mem_data = 32'h0;
   logic          dump_valid;
   logic          dump_ready = 1'b0;
   logic [AW-1:0] dump_address;
   logic [31:0]   dump_data;
   logic          dump_done;

   int n_checks = 0;
   int n_fail   = 0;
   int n_reads  = 0;

   logic [31:0] mem [4];
   logic [31:0] hs_addr_q[$];
   logic [31:0] hs_data_q[$];

   logic [31:0] exp_addr [4];
   logic [31:0] exp_data [4];
   int          exp_n;

   memory_dump_unit #(.ADDRESS_WIDTH(AW)) dut (
      .CLK             (CLK),
      .reset           (reset),
      .halt            (halt),
      .mem_read_enable (mem_read_enable),
      .mem_address     (mem_address),
      .mem_data        (mem_data),
      .dump_valid      (dump_valid),
      .dump_ready      (dump_ready),
      .dump_address    (dump_address),
      .dump_data       (dump_data),
      .dump_done       (dump_done)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (mem_read_enable) begin
         mem_data <= mem[mem_address[3:2]];
         n_reads  <= n_reads + 1;
      end
   end

   // a handshake seen here completes at the following rising edge
   always @(negedge CLK) begin
      if (!reset && dump_valid && dump_ready) begin
         hs_addr_q.push_back(32'(dump_address));
         hs_data_q.push_back(dump_data);
      end
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      halt = 1'b0;
      dump_ready = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      hs_addr_q.delete();
      hs_data_q.delete();
   endtask

   task automatic wait_done(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         if (dump_done) break;
         tick();
      end
      check_val("done_reached", 32'(dump_done), 32'd1);
   endtask

   task automatic check_handshakes(input string tag);
      check_val({tag, "_count"}, 32'(hs_addr_q.size()), 32'(exp_n));
      for (int i = 0; i < exp_n; i++) begin
         if (i < hs_addr_q.size()) begin
            check_val({tag, "_addr"}, hs_addr_q[i], exp_addr[i]);
            check_val({tag, "_data"}, hs_data_q[i], exp_data[i]);
         end
      end
   endtask

   // pulses ready for every word before the target address, stops with the target offered
   task automatic run_to_addr(input logic [31:0] target);
      bit found = 1'b0;
      for (int i = 0; i < 60; i++) begin
         tick();
         if (dump_valid && (32'(dump_address) == target) && !dump_ready) begin
            found = 1'b1;
            break;
         end
         dump_ready = dump_valid && (32'(dump_address) != target);
      end
      check_val("reach_target", 32'(found), 32'd1);
   endtask

   int base_reads;
   int snap_reads;

   initial begin
      mem[0] = 32'h11223344;
      mem[1] = 32'h00000000;
      mem[2] = 32'hDEADBEEF;
      mem[3] = 32'hCAFEF00D;
`ifdef DUMP_SKIP_ZERO_EN
      exp_n = 3;
      exp_addr[0] = 32'h0; exp_data[0] = 32'h11223344;
      exp_addr[1] = 32'h8; exp_data[1] = 32'hDEADBEEF;
      exp_addr[2] = 32'hC; exp_data[2] = 32'hCAFEF00D;
      exp_addr[3] = 32'h0; exp_data[3] = 32'h0;
`else
      exp_n = 4;
      exp_addr[0] = 32'h0; exp_data[0] = 32'h11223344;
      exp_addr[1] = 32'h4; exp_data[1] = 32'h00000000;
      exp_addr[2] = 32'h8; exp_data[2] = 32'hDEADBEEF;
      exp_addr[3] = 32'hC; exp_data[3] = 32'hCAFEF00D;
`endif

      // reset state
      #2;
      check_val("rst_valid", 32'(dump_valid), 32'd0);
      check_val("rst_done", 32'(dump_done), 32'd0);
      check_val("rst_rden", 32'(mem_read_enable), 32'd0);
      check_val("rst_maddr", 32'(mem_address), 32'd0);
      check_val("rst_daddr", 32'(dump_address), 32'd0);
      check_val("rst_ddata", dump_data, 32'd0);
      apply_reset();

      // full dump with ready held high, latency checked edge by edge
      base_reads = n_reads;
      dump_ready = 1'b1;
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check_val("lat_rden", 32'(mem_read_enable), 32'd1);
      check_val("lat_maddr", 32'(mem_address), 32'd0);
      check_val("lat_valid_e1", 32'(dump_valid), 32'd0);
      tick();
      check_val("lat_valid_e2", 32'(dump_valid), 32'd0);
      check_val("lat_rden_wait", 32'(mem_read_enable), 32'd0);
      tick();
      check_val("lat_valid_e3", 32'(dump_valid), 32'd1);
      check_val("first_addr", 32'(dump_address), 32'h0);
      check_val("first_data", dump_data, 32'h11223344);
      wait_done(40);
      check_handshakes("full");
      check_val("full_reads", 32'(n_reads - base_reads), 32'd4);
      check_val("done_valid", 32'(dump_valid), 32'd0);
      check_val("done_rden", 32'(mem_read_enable), 32'd0);

      // stall on address 8 for five cycles
      apply_reset();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      run_to_addr(32'h8);
      snap_reads = n_reads;
      for (int i = 0; i < 5; i++) begin
         tick();
         check_val("stall_valid", 32'(dump_valid), 32'd1);
         check_val("stall_addr", 32'(dump_address), 32'h8);
         check_val("stall_data", dump_data, 32'hDEADBEEF);
      end
      check_val("stall_reads", 32'(n_reads), 32'(snap_reads));
      dump_ready = 1'b1;
      wait_done(40);
      check_handshakes("stall");

      // asynchronous reset mid-cycle while a word is offered, then a clean restart
      apply_reset();
      halt = 1'b1;
      tick();
      halt = 1'b0;
      run_to_addr(exp_addr[1]);
      #2;
      reset = 1'b1;
      #1;
      check_val("arst_valid", 32'(dump_valid), 32'd0);
      check_val("arst_done", 32'(dump_done), 32'd0);
      check_val("arst_rden", 32'(mem_read_enable), 32'd0);
      check_val("arst_maddr", 32'(mem_address), 32'd0);
      check_val("arst_daddr", 32'(dump_address), 32'd0);
      check_val("arst_ddata", dump_data, 32'd0);
      apply_reset();
      dump_ready = 1'b1;
      halt = 1'b1;
      tick();
      halt = 1'b0;
      wait_done(40);
      check_handshakes("restart");

      // halt toggling during the dump and held high afterwards
      apply_reset();
      base_reads = n_reads;
      dump_ready = 1'b1;
      halt = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (dump_done) break;
         halt = ~halt;
      end
      halt = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check_handshakes("toggle");
      check_val("toggle_reads", 32'(n_reads - base_reads), 32'd4);
      check_val("toggle_done", 32'(dump_done), 32'd1);
      check_val("toggle_rden", 32'(mem_read_enable), 32'd0);
      check_val("toggle_valid", 32'(dump_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/memory_dump_unit.md
MEMORY_DUMP_UNIT -- requirements
Module: memory_dump_unit

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 12, byte-address width of the data memory being dumped.
REQ-002 SHALL have port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port halt  input  1  core halted (EBREAK retired); level, sampled only in IDLE.
REQ-005 SHALL have port mem_read_enable  output  1  read strobe to data memory read port.
REQ-006 SHALL have port mem_address  output  ADDRESS_WIDTH  word-aligned byte address of read.
REQ-007 SHALL have port mem_data  input  32  read data, valid exactly one cycle after the mem_read_enable cycle; bits [7:0] = byte at mem_address.
REQ-008 SHALL have port dump_valid  output  1  dump word offered.
REQ-009 SHALL have port dump_ready  input  1  sink accepts dump word.
REQ-010 SHALL have port dump_address  output  ADDRESS_WIDTH  byte address of offered word.
REQ-011 SHALL have port dump_data  output  32  offered word, same byte order as mem_data.
REQ-012 SHALL have port dump_done  output  1  dump complete.

Function
REQ-013 SHALL implement states IDLE, READ, WAIT, SEND, DONE.
REQ-014 IDLE: halt=1 at an edge SHALL load address counter 0 and go to READ; halt=0 SHALL stay in IDLE.
REQ-015 READ: mem_read_enable=1 and mem_address=counter for exactly one cycle, then WAIT; mem_read_enable SHALL be 0 in all other states.
REQ-016 WAIT: mem_data SHALL be registered into dump_data, counter into dump_address, then SEND; latency from halt edge to dump_valid=1 is 3 cycles.
REQ-017 SEND: dump_valid=1; dump_address/dump_data SHALL stay stable until dump_valid && dump_ready at an edge.
REQ-018 Handshake at an edge with counter != 2^ADDRESS_WIDTH-4: counter += 4, go to READ; one word per 3 cycles max with dump_ready held high.
REQ-019 Handshake with counter == 2^ADDRESS_WIDTH-4: go to DONE; counter SHALL NOT wrap to 0 and restart.
REQ-020 DONE: dump_done=1, dump_valid=0; sticky until reset; halt ignored.
REQ-021 halt changes while in READ/WAIT/SEND SHALL be ignored; dump always runs to completion.
REQ-022 dump_ready high outside SEND SHALL have no effect.
REQ-023 Addresses SHALL be emitted strictly ascending, stride 4, from 0.

Reset
REQ-024 reset=1 SHALL immediately force IDLE, counter=0, dump_valid=0, dump_done=0, mem_read_enable=0, mem_address=0, dump_address=0, dump_data=0, independent of CLK.
REQ-025 reset mid-dump SHALL abort; after release, a new halt restarts from address 0.

Configuration
REQ-026 Macro DUMP_SKIP_ZERO_EN SHALL control zero-word suppression.
REQ-027 With DUMP_SKIP_ZERO_EN defined: in WAIT, mem_data==0 SHALL skip SEND and advance as if handshaken (READ at counter+4, or DONE if last address).
REQ-028 Without DUMP_SKIP_ZERO_EN: every word, zero or not, SHALL be offered; 2^ADDRESS_WIDTH/4 handshakes total.

Verification (ADDRESS_WIDTH=4, memory words 0x11223344, 0, 0xDEADBEEF, 0xCAFEF00D)
REQ-029 Macro off, dump_ready=1, halt pulsed -> 4 handshakes: (0,0x11223344),(4,0),(8,0xDEADBEEF),(C,0xCAFEF00D); first dump_valid 3 cycles after halt edge; dump_done=1 after 4th.
REQ-030 Macro on, same stimulus -> 3 handshakes at addresses 0, 8, C; address 4 never offered; dump_done=1.
REQ-031 dump_ready low 5 cycles during address 8 -> dump_valid held, dump_address=8, dump_data=0xDEADBEEF stable all 5 cycles; no extra memory reads.
REQ-032 reset asserted mid-cycle while in SEND at address 4 -> all outputs 0 before next CLK edge; re-halt dumps from address 0.
REQ-033 halt toggled during dump and held after DONE -> exactly 4 handshakes (macro off), dump_done stays 1, mem_read_enable stays 0.
